// File: rtl/multdiv_pkg.sv
// Shared decode constants and enums for the multi-cycle multiply/divide unit.
package multdiv_pkg;

    localparam logic [4:0] OPC_RTYPE = 5'd0;
    localparam logic [4:0] ALU_MULT  = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } md_state_e;

    typedef enum logic {
        MD_MULT,
        MD_DIV
    } md_op_e;

endpackage

// File: rtl/multdiv_iter_engine.sv
// Iterative signed multiply / restoring divide datapath on operand magnitudes,
// resolving BITS_PER_CYCLE result bits per clock once loaded.
module multdiv_iter_engine
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             last
);

    localparam int unsigned LAT = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CW  = $clog2(LAT + 1);

    md_op_e             op_q, op_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH:0]     prod_top;

    assign a_mag = a[WIDTH-1] ? -a : a;
    assign b_mag = b[WIDTH-1] ? -b : b;

    always_comb begin
        op_d      = op_q;
        neg_d     = neg_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        if (load) begin
            op_d      = op;
            neg_d     = a[WIDTH-1] ^ b[WIDTH-1];
            acc_d     = '0;
            mcand_d   = {{WIDTH{1'b0}}, a_mag};
            mplier_d  = b_mag;
            rem_d     = '0;
            quo_d     = a_mag;
            divisor_d = b_mag;
            cnt_d     = CW'(LAT);
        end else if (cnt_q != '0) begin
            for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
                if (op_q == MD_MULT) begin
                    if (mplier_d[0]) acc_d = acc_d + mcand_d;
                    mcand_d  = mcand_d << 1;
                    mplier_d = mplier_d >> 1;
                end else begin
                    // Partial remainder stays below the divisor, so its MSB is free to shift.
                    {rem_d, quo_d} = {rem_d, quo_d} << 1;
                    if (rem_d >= divisor_q) begin
                        rem_d    = rem_d - divisor_q;
                        quo_d[0] = 1'b1;
                    end
                end
            end
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q      <= MD_MULT;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
        end else begin
            op_q      <= op_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
        end
    end

    assign prod     = neg_q ? -acc_q : acc_q;
    assign quot     = neg_q ? -quo_q : quo_q;
    assign prod_top = prod[2*WIDTH-1:WIDTH-1];
    assign last     = (cnt_q == CW'(1));

    // A positive quotient with the MSB set only arises from MIN / -1.
    always_comb begin
        if (op_q == MD_MULT) begin
            result   = prod[WIDTH-1:0];
            overflow = ~((&prod_top) | ~(|prod_top));
        end else begin
            result   = quot;
            overflow = ~neg_q & quo_q[WIDTH-1];
        end
    end

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// Execute-stage mult/div controller: decode, operand capture, pipeline stall,
// flush cancel, divide-by-zero early out and exception qualification.
module multdiv_seq_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic             flush,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             is_multdiv,
    output logic             stall,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       result_rd,
    output logic             exception_mult,
    output logic             exception_div
);

    md_state_e        state_q, state_d;
    md_op_e           op_dec, op_q;
    logic             start, div0, eng_load;
    logic [4:0]       rd_q;
    logic             div0_q;
    logic [WIDTH-1:0] eng_result;
    logic             eng_overflow, eng_last;

    logic [WIDTH-1:0] done_result;
    logic             done_exc_mult, done_exc_div;
    logic [WIDTH-1:0] result_hold_q;
    logic [4:0]       rd_hold_q;
    logic             exc_mult_hold_q, exc_div_hold_q;

    logic unused_instr;
    assign unused_instr = ^{instr[21:7], instr[1:0]};

    assign is_multdiv = instr_valid && (instr[31:27] == OPC_RTYPE) &&
                        ((instr[6:2] == ALU_MULT) || (instr[6:2] == ALU_DIV));
    assign op_dec     = (instr[6:2] == ALU_DIV) ? MD_DIV : MD_MULT;
    assign start      = is_multdiv && !flush && (state_q == IDLE);
    assign div0       = (op_dec == MD_DIV) && (operand_b == '0);
    assign eng_load   = start && !div0;

    multdiv_iter_engine #(
        .WIDTH         (WIDTH),
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_engine (
        .clock   (clock),
        .reset   (reset),
        .load    (eng_load),
        .op      (op_dec),
        .a       (operand_a),
        .b       (operand_b),
        .result  (eng_result),
        .overflow(eng_overflow),
        .last    (eng_last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = div0 ? DONE : BUSY;
            BUSY: begin
                if (flush)         state_d = IDLE;
                else if (eng_last) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            op_q            <= MD_MULT;
            rd_q            <= '0;
            div0_q          <= 1'b0;
            result_hold_q   <= '0;
            rd_hold_q       <= '0;
            exc_mult_hold_q <= 1'b0;
            exc_div_hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_q   <= op_dec;
                rd_q   <= instr[26:22];
                div0_q <= div0;
            end
            if (state_q == DONE) begin
                result_hold_q   <= done_result;
                rd_hold_q       <= rd_q;
                exc_mult_hold_q <= done_exc_mult;
                exc_div_hold_q  <= done_exc_div;
            end
        end
    end

    // The engine is never loaded for a zero divisor, so its result is ignored then.
    assign done_result   = div0_q ? '0 : eng_result;
    assign done_exc_mult = (op_q == MD_MULT) && eng_overflow;
    assign done_exc_div  = (op_q == MD_DIV) && (div0_q || eng_overflow);

    assign stall          = ((state_q == IDLE) && start) || ((state_q == BUSY) && !flush);
    assign busy           = (state_q == BUSY);
    assign result_valid   = (state_q == DONE);
    assign result         = result_valid ? done_result   : result_hold_q;
    assign result_rd      = result_valid ? rd_q          : rd_hold_q;
    assign exception_mult = result_valid ? done_exc_mult : exc_mult_hold_q;
    assign exception_div  = result_valid ? done_exc_div  : exc_div_hold_q;

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// Randomised and directed checks of two controller instances (1 and 4 bits/cycle)
// against a cycle-level behavioural model built on plain integer arithmetic.
module tb_multdiv_seq_ctrl;

    logic        clock = 1'b0;
    logic        rst   [2];
    logic [31:0] instr [2];
    logic        iv    [2];
    logic        fl    [2];
    logic [31:0] opa   [2];
    logic [31:0] opb   [2];
    logic        ismd  [2];
    logic        stall [2];
    logic        busy  [2];
    logic        rv    [2];
    logic [31:0] res   [2];
    logic [4:0]  rd    [2];
    logic        em    [2];
    logic        ed    [2];

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int lat_of [2] = '{32, 8};

    // Model state: remaining busy cycles, pending result, last delivered result.
    int          m_left [2];
    bit          m_done [2];
    bit          armed  [2] = '{1'b0, 1'b0};
    logic [31:0] p_res  [2];
    logic [4:0]  p_rd   [2];
    bit          p_em   [2];
    bit          p_ed   [2];
    logic [31:0] h_res  [2];
    logic [4:0]  h_rd   [2];
    bit          h_em   [2];
    bit          h_ed   [2];

    logic [31:0] g_res [2];
    logic [4:0]  g_rd  [2];
    logic        g_em  [2];
    logic        g_ed  [2];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    multdiv_seq_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut0 (
        .clock(clock), .reset(rst[0]), .instr(instr[0]), .instr_valid(iv[0]),
        .flush(fl[0]), .operand_a(opa[0]), .operand_b(opb[0]), .is_multdiv(ismd[0]),
        .stall(stall[0]), .busy(busy[0]), .result_valid(rv[0]), .result(res[0]),
        .result_rd(rd[0]), .exception_mult(em[0]), .exception_div(ed[0])
    );

    multdiv_seq_ctrl #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut1 (
        .clock(clock), .reset(rst[1]), .instr(instr[1]), .instr_valid(iv[1]),
        .flush(fl[1]), .operand_a(opa[1]), .operand_b(opb[1]), .is_multdiv(ismd[1]),
        .stall(stall[1]), .busy(busy[1]), .result_valid(rv[1]), .result(res[1]),
        .result_rd(rd[1]), .exception_mult(em[1]), .exception_div(ed[1])
    );

    task automatic chk(input string name, input int u, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s unit%0d: got %h, expected %h", name, u, got, exp);
        end
    endtask

    function automatic void ref_calc(input bit is_div, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r,
                                     output bit xm, output bit xd);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint p;
        logic signed [31:0] lo;
        xm = 1'b0;
        xd = 1'b0;
        if (!is_div) begin
            p  = sa * sb;
            lo = p[31:0];
            r  = lo;
            xm = (p != longint'(lo));
        end else if (b == 32'd0) begin
            r  = 32'd0;
            xd = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r  = a;
            xd = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
        end
    endfunction

    function automatic logic [31:0] mk(input bit d, input logic [4:0] r);
        logic [14:0] f = 15'($urandom);
        logic [1:0]  t = 2'($urandom);
        return {5'd0, r, f, d ? 5'b00111 : 5'b00110, t};
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 200)) - 32'd100;
            default: return $urandom;
        endcase
    endfunction

    // Compare process: checks every cycle, then advances the model on current inputs.
    initial begin
        forever begin
            @(negedge clock);
            for (int u = 0; u < 2; u++) begin
                bit dec, idle, e_stall, is_div;
                dec = iv[u] && (instr[u][31:27] == 5'd0) &&
                      (instr[u][6:2] == 5'b00110 || instr[u][6:2] == 5'b00111);
                is_div = (instr[u][6:2] == 5'b00111);
                if (!armed[u]) begin
                    if (rst[u] === 1'b1) begin
                        armed[u]  = 1'b1;
                        m_left[u] = 0;
                        m_done[u] = 1'b0;
                        h_res[u] = '0; h_rd[u] = '0; h_em[u] = 1'b0; h_ed[u] = 1'b0;
                    end
                    continue;
                end
                idle    = (m_left[u] == 0) && !m_done[u];
                e_stall = idle ? (dec && !fl[u]) : ((m_left[u] > 0) && !fl[u]);
                chk("is_multdiv", u, ismd[u], dec);
                chk("stall", u, stall[u], e_stall);
                chk("busy", u, busy[u], m_left[u] > 0);
                chk("result_valid", u, rv[u], m_done[u]);
                if (m_done[u]) begin
                    chk("result", u, res[u], p_res[u]);
                    chk("result_rd", u, rd[u], p_rd[u]);
                    chk("exception_mult", u, em[u], p_em[u]);
                    chk("exception_div", u, ed[u], p_ed[u]);
                end else if (idle) begin
                    chk("held_result", u, res[u], h_res[u]);
                    chk("held_rd", u, rd[u], h_rd[u]);
                    chk("held_exc_mult", u, em[u], h_em[u]);
                    chk("held_exc_div", u, ed[u], h_ed[u]);
                end
                if (rst[u]) begin
                    m_left[u] = 0;
                    m_done[u] = 1'b0;
                    h_res[u] = '0; h_rd[u] = '0; h_em[u] = 1'b0; h_ed[u] = 1'b0;
                end else if (m_done[u]) begin
                    m_done[u] = 1'b0;
                    h_res[u] = p_res[u]; h_rd[u] = p_rd[u]; h_em[u] = p_em[u]; h_ed[u] = p_ed[u];
                end else if (m_left[u] > 0) begin
                    if (fl[u]) m_left[u] = 0;
                    else if (m_left[u] == 1) begin
                        m_left[u] = 0;
                        m_done[u] = 1'b1;
                    end else m_left[u]--;
                end else if (dec && !fl[u]) begin
                    ref_calc(is_div, opa[u], opb[u], p_res[u], p_em[u], p_ed[u]);
                    p_rd[u] = instr[u][26:22];
                    if (is_div && opb[u] == 32'd0) m_done[u] = 1'b1;
                    else m_left[u] = lat_of[u];
                end
            end
        end
    end

    // Holds the instruction in X until its result appears (or until the flush cycle).
    task automatic run_op(input int u, input bit is_div, input logic [4:0] rdn,
                          input logic [31:0] a, input logic [31:0] b, input int kill_at,
                          output int lat, output int stalls, output int s);
        bit seen = 1'b0;
        lat    = -1;
        stalls = 0;
        @(posedge clock); #1;
        instr[u] = mk(is_div, rdn); iv[u] = 1'b1; fl[u] = 1'b0; opa[u] = a; opb[u] = b;
        s = cyc;
        for (int c = 0; c < 200; c++) begin
            if (c > 0) begin
                @(posedge clock); #1;
                opa[u] = $urandom;
                opb[u] = $urandom;
                if (c == kill_at) fl[u] = 1'b1;
            end
            @(negedge clock);
            if (stall[u]) stalls++;
            if (rv[u]) begin
                seen = 1'b1;
                lat  = cyc - s;
                g_res[u] = res[u]; g_rd[u] = rd[u]; g_em[u] = em[u]; g_ed[u] = ed[u];
            end
            if (seen || c == kill_at) break;
        end
        if (fl[u]) begin
            @(posedge clock); #1;
            fl[u] = 1'b0;
            iv[u] = 1'b0;
        end else if (kill_at < 0) begin
            chk("result_timeout", u, 32'(seen), 32'd1);
        end
    endtask

    task automatic idle(input int u, input int n, input bit noisy);
        for (int i = 0; i < n; i++) begin
            logic [31:0] j = $urandom;
            @(posedge clock); #1;
            if (noisy && $urandom_range(0, 1) == 1) begin
                if ($urandom_range(0, 1) == 1) j[31:27] = 5'($urandom_range(1, 31));
                else begin
                    j[31:27] = 5'd0;
                    j[6:2]   = 5'($urandom_range(8, 31));
                end
                instr[u] = j;
                iv[u]    = 1'b1;
            end else iv[u] = 1'b0;
            fl[u]  = noisy && ($urandom_range(0, 3) == 0);
            opa[u] = $urandom;
            opb[u] = $urandom;
        end
        @(posedge clock); #1;
        fl[u] = 1'b0;
        iv[u] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, st, s0, s1;
        logic [31:0] r;
        bit xm, xd;
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; iv[u] = 1'b0; fl[u] = 1'b0;
            instr[u] = '0; opa[u] = '0; opb[u] = '0;
        end
        repeat (3) @(posedge clock);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        ref_calc(1'b0, 32'd7, 32'hFFFF_FFFD, r, xm, xd);
        chk("model_mul_7x-3", 0, r, 32'hFFFF_FFEB);
        ref_calc(1'b1, 32'd100, 32'hFFFF_FFF9, r, xm, xd);
        chk("model_div_100/-7", 0, r, 32'hFFFF_FFF2);
        ref_calc(1'b0, 32'h4000_0000, 32'd4, r, xm, xd);
        chk("model_mul_ovf", 0, {r[30:0], xm}, 32'd1);
        ref_calc(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, r, xm, xd);
        chk("model_div_ovf", 0, {r[31], xd}, 32'd3);

        // Unit 0: one result bit per cycle.
        run_op(0, 1'b0, 5'd5, 32'd7, 32'hFFFF_FFFD, -1, lat, st, s0);
        chk("mul_latency", 0, lat, 33);
        chk("mul_stall_cycles", 0, st, 33);
        chk("mul_result", 0, g_res[0], 32'hFFFF_FFEB);
        chk("mul_rd", 0, g_rd[0], 32'd5);
        chk("mul_exc", 0, g_em[0], 32'd0);
        run_op(0, 1'b1, 5'd7, 32'd100, 32'hFFFF_FFF9, -1, lat, st, s0);
        chk("div_result", 0, g_res[0], 32'hFFFF_FFF2);
        chk("div_exc", 0, g_ed[0], 32'd0);
        run_op(0, 1'b1, 5'd8, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat, st, s1);
        chk("div_b2b_start", 0, s1 - s0, 34);
        chk("div_min_result", 0, g_res[0], 32'h8000_0000);
        chk("div_min_exc", 0, g_ed[0], 32'd1);
        run_op(0, 1'b1, 5'd2, 32'd5, 32'd0, -1, lat, st, s0);
        chk("div0_latency", 0, lat, 1);
        chk("div0_stall_cycles", 0, st, 1);
        chk("div0_result", 0, g_res[0], 32'd0);
        chk("div0_exc", 0, g_ed[0], 32'd1);
        run_op(0, 1'b0, 5'd3, 32'h4000_0000, 32'd4, -1, lat, st, s0);
        chk("mul_ovf_result", 0, g_res[0], 32'd0);
        chk("mul_ovf_exc", 0, g_em[0], 32'd1);
        run_op(0, 1'b0, 5'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, lat, st, s0);
        chk("mul_m1_result", 0, g_res[0], 32'd1);
        chk("mul_m1_exc", 0, g_em[0], 32'd0);
        run_op(0, 1'b0, 5'd3, 32'h12345, 32'h6789, 10, lat, st, s0);
        chk("flush_no_result", 0, lat, 32'hFFFF_FFFF);
        run_op(0, 1'b0, 5'd9, 32'd12, 32'hFFFF_FFF4, -1, lat, st, s0);
        chk("post_flush_result", 0, g_res[0], 32'hFFFF_FF70);
        chk("post_flush_rd", 0, g_rd[0], 32'd9);
        chk("post_flush_latency", 0, lat, 33);
        idle(0, 2, 1'b0);

        // Unit 1: four result bits per cycle.
        run_op(1, 1'b0, 5'd4, 32'd1234, 32'd5678, -1, lat, st, s0);
        chk("bpc4_mul_latency", 1, lat, 9);
        chk("bpc4_mul_result", 1, g_res[1], 32'd7006652);
        run_op(1, 1'b1, 5'd6, 32'hFFFF_FC18, 32'd7, -1, lat, st, s1);
        chk("bpc4_b2b_start", 1, s1 - s0, 10);
        chk("bpc4_div_result", 1, g_res[1], 32'hFFFF_FF72);
        chk("bpc4_div_rd", 1, g_rd[1], 32'd6);
        @(posedge clock); #1;
        instr[1] = mk(1'b0, 5'd11); iv[1] = 1'b1; opa[1] = 32'd3; opb[1] = 32'd4;
        repeat (3) begin
            @(posedge clock); #1;
        end
        rst[1] = 1'b1;
        iv[1]  = 1'b0;
        @(posedge clock); #1;
        rst[1] = 1'b0;
        @(negedge clock);
        chk("reset_busy", 1, busy[1], 32'd0);
        chk("reset_result", 1, res[1], 32'd0);
        chk("reset_rd", 1, rd[1], 32'd0);
        chk("reset_exc", 1, {em[1], ed[1], rv[1], stall[1]}, 32'd0);
        idle(1, 12, 1'b0);

        // Random traffic on both instances.
        for (int k = 0; k < 120; k++) begin
            int u    = int'($urandom_range(0, 1));
            int kill = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, lat_of[u])) : -1;
            run_op(u, 1'($urandom_range(0, 1)), 5'($urandom), rnd_opnd(), rnd_opnd(), kill,
                   lat, st, s0);
            if ($urandom_range(0, 2) == 0) idle(u, int'($urandom_range(0, 3)), 1'b1);
        end
        idle(0, 2, 1'b0);
        idle(1, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/multdiv_seq_ctrl.md
Name: multdiv_seq_ctrl

Overview:
- Parametrised multi-cycle multiply/divide controller for the execute stage.
- Decodes R-type mult/div from the instruction in X and captures the operands.
- Runs an internal iterative engine at a configurable bits-per-cycle rate and holds the pipeline stall until the result is ready.
- Adds flush cancel, a divide-by-zero early out, a tagged writeback destination and an overflow exception.

Parameters:
- WIDTH, 32: operand and result width; even, 8..64.
- BITS_PER_CYCLE, 1: result bits resolved per engine cycle; one of 1, 2, 4; must divide WIDTH.
- LAT, WIDTH/BITS_PER_CYCLE: derived engine iteration count; not overridable.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  32  instruction currently in X.
- instr_valid  in  1  instr is a live (non-bubble) instruction.
- flush  in  1  cancel any in-flight or starting operation (branch/jump kill).
- operand_a  in  WIDTH  rs value for instr; two's complement.
- operand_b  in  WIDTH  rt value for instr; two's complement.
- is_multdiv  out  1  combinational: instr_valid and instr decodes as mult or div.
- stall  out  1  hold F/D/X stages.
- busy  out  1  state is BUSY.
- result_valid  out  1  one-cycle pulse; result fields are valid.
- result  out  WIDTH  product low half or quotient.
- result_rd  out  5  destination register (instr[26:22] captured at start).
- exception_mult  out  1  qualified by result_valid.
- exception_div  out  1  qualified by result_valid.

Behaviour:
- Decode: opcode instr[31:27]==5'd0. ALU op instr[6:2]==5'b00110 is mult; 5'b00111 is div.
- start = is_multdiv and ~flush and state==IDLE.
- States:
  - IDLE: on start, capture operand_a, operand_b, op and instr[26:22], then go to BUSY. Exception: div with operand_b==0 goes to DONE.
  - BUSY: engine iterates once per cycle. After LAT iterations go to DONE. flush goes to IDLE and discards the result.
  - DONE: result_valid=1 for one cycle, then unconditionally IDLE. No start is evaluated in DONE, so the same instruction cannot re-trigger.
- stall = (state==IDLE and start) or (state==BUSY and ~flush). stall is combinational in the decode cycle and low in DONE.
- Timing for start in cycle S:
  - stall is high for S..S+LAT.
  - result_valid is high at S+LAT+1, while the instruction is still in X; the pipeline advances at the end of that cycle.
  - Divide-by-zero: stall high in S only, result_valid at S+1.
- Back-to-back mult/div: the next one starts in the cycle after DONE; no idle gap beyond that.
- Mult:
  - Signed; result = low WIDTH bits of the 2*WIDTH product.
  - exception_mult=1 when the full product differs from the sign-extension of its low half.
- Div:
  - Signed restoring division on magnitudes; quotient truncated toward zero; sign = sign(a) XOR sign(b); remainder discarded.
  - Divide-by-zero: result=0, exception_div=1.
  - MIN / -1: result=MIN, exception_div=1.
- Engine steps BITS_PER_CYCLE radix-2 iterations combinationally per clock.
- The operand registers are frozen after capture, so operand input changes during BUSY are ignored.
- Reset (any state, including mid-BUSY): next state IDLE. result, result_rd, the exceptions, result_valid and busy are all 0, and engine registers are cleared. stall is then 0 unless start holds in that IDLE cycle.
- flush in the same cycle as result_valid has no effect on that result; the pipeline owns the kill.
- All outputs except result_valid/busy/stall hold their last value in IDLE.

Decomposition:
- Package multdiv_pkg holds:
  - OPC_RTYPE=5'd0, ALU_MULT=5'b00110, ALU_DIV=5'b00111.
  - State encoding IDLE/BUSY/DONE.
  - Op enum MD_MULT/MD_DIV.
- Sub-module multdiv_iter_engine (WIDTH, BITS_PER_CYCLE) handles the datapath only:
  - Inputs: clock, reset, load, op, a, b.
  - Outputs: result, overflow, last.
  - Contents: shift-add accumulator and restoring-divide remainder/quotient registers plus the iteration counter.
- The controller holds the FSM, decode, capture, stall and exception qualification.

Test Plan:
- WIDTH=32, BPC=1, mult rd=5, 7 * -3 started at cycle S -> stall high for 33 cycles, result_valid at S+33, result=32'hFFFFFFEB, result_rd=5, exception_mult=0.
- div 100 / -7 -> result=32'hFFFFFFF2 (-14), exception_div=0. Then div 32'h80000000 / -1 -> result=32'h80000000, exception_div=1.
- div 5 / 0 -> stall only in S, result_valid at S+1, result=0, exception_div=1.
- mult 32'h40000000 * 4 -> result=0, exception_mult=1. Then mult 32'hFFFF_FFFF * 32'hFFFF_FFFF -> result=1, exception_mult=0.
- flush on the 10th BUSY cycle -> stall low that cycle, no result_valid ever for that op. A mult issued two cycles later completes normally with correct value and rd.
- BPC=4: mult 1234 * 5678 -> result_valid at S+9, result=7006652. Back-to-back div follows with start at S+10. Reset asserted mid-BUSY -> IDLE next cycle, all outputs 0, no result_valid.
